// File: rtl/usi_pattern_tx_pkg.sv
// Shared types for the USI pattern-playback transmitter.
// Optional repeat feature is enabled by defining USI_TX_REPEAT_EN.
package usi_pattern_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PLAY,
    ST_DONE
  } tx_state_t;

  localparam int REPEAT_WIDTH = 16;

endpackage

// File: rtl/usi_pattern_ram.sv
// Simple dual-port pattern RAM: synchronous write, registered read (1-cycle latency).
// A same-cycle write and read of one address returns the old word.
module usi_pattern_ram #(
  parameter int WIDTH      = 1,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/usi_pattern_tx.sv
// Multi-channel pattern-playback transmitter: FSM, run edge detect, counters, dataout.
// Define USI_TX_REPEAT_EN to add repeat_count (pattern plays repeat_count+1 times).
module usi_pattern_tx
  import usi_pattern_tx_pkg::*;
#(
  parameter int CHANNELS   = 1,
  parameter int ADDR_WIDTH = 10,
  parameter int DIV_WIDTH  = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  output logic                  done,
  output logic                  busy,
  output logic [CHANNELS-1:0]   dataout,
  input  logic [CHANNELS-1:0]   idle_level,
  input  logic [ADDR_WIDTH:0]   num_states,
  input  logic [DIV_WIDTH-1:0]  clkdivider,
  input  logic                  state_prog_en,
  input  logic [ADDR_WIDTH-1:0] state_prog_addr,
  input  logic                  state_prog_wr,
  input  logic [CHANNELS-1:0]   state_prog_data
`ifdef USI_TX_REPEAT_EN
  ,
  input  logic [REPEAT_WIDTH-1:0] repeat_count
`endif
);

  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  tx_state_t             state_q, state_d;
  logic                  run_d, done_q, done_d, busy_q, busy_d;
  logic [CHANNELS-1:0]   dout_q, dout_d, rd_data;
  logic [ADDR_WIDTH:0]   addr_q, addr_d, num_q, num_d, addr_inc, num_clamped;
  logic [DIV_WIDTH-1:0]  div_q, div_d, cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  wr_en, start, rep_more;
`ifdef USI_TX_REPEAT_EN
  logic [REPEAT_WIDTH-1:0] rep_q, rep_d;
  assign rep_more = (rep_q != '0);
`else
  assign rep_more = 1'b0;
`endif

  assign start       = run && !run_d;
  assign wr_en       = state_prog_en && state_prog_wr && !busy_q;
  assign num_clamped = (num_states > DEPTH) ? DEPTH : num_states;
  assign addr_inc    = addr_q + 1'b1;
  // RAM reads the next address so rd_data always holds mem[addr_q] (next state to show).
  assign rd_addr     = addr_d[ADDR_WIDTH-1:0];
  assign dataout     = (state_q == ST_PLAY) ? dout_q : idle_level;
  assign done        = done_q;
  assign busy        = busy_q;

  usi_pattern_ram #(
    .WIDTH      (CHANNELS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (state_prog_addr),
    .wr_data (state_prog_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    busy_d  = busy_q;
    dout_d  = dout_q;
    addr_d  = addr_q;
    num_d   = num_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
`ifdef USI_TX_REPEAT_EN
    rep_d   = rep_q;
`endif
    case (state_q)
      ST_IDLE: begin
        addr_d = '0;
        if (start) begin
          num_d = num_clamped;
          div_d = clkdivider;
`ifdef USI_TX_REPEAT_EN
          rep_d = repeat_count;
`endif
          if (num_clamped == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_LOAD;
            busy_d  = 1'b1;
          end
        end
      end
      ST_LOAD, ST_PLAY: begin
        if (!run) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b0;
          addr_d  = '0;
        end else if (state_q == ST_PLAY && cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (state_q == ST_PLAY && addr_q == num_q) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          addr_d  = '0;
        end else begin
          // Advance: show prefetched word; wrap to 0 early when another pass follows.
          state_d = ST_PLAY;
          dout_d  = rd_data;
          cnt_d   = div_q;
          if (addr_inc == num_q && rep_more) begin
            addr_d = '0;
`ifdef USI_TX_REPEAT_EN
            rep_d  = rep_q - 1'b1;
`endif
          end else begin
            addr_d = addr_inc;
          end
        end
      end
      ST_DONE: begin
        if (!run) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      run_d   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      dout_q  <= '0;
      addr_q  <= '0;
      num_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
`ifdef USI_TX_REPEAT_EN
      rep_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      run_d   <= run;
      done_q  <= done_d;
      busy_q  <= busy_d;
      dout_q  <= dout_d;
      addr_q  <= addr_d;
      num_q   <= num_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
`ifdef USI_TX_REPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

endmodule
